// File: rtl/mul_seq.sv
// mul_seq: sequential radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Runs in lockstep with the iterative divider; the control unit stalls on busy.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rstn       in   synchronous reset, ACTIVE HIGH despite the name
//   start      in   operation request, only accepted in IDLE
//   sign       in   1 = signed two's-complement operands, 0 = unsigned
//   data_s     in   multiplicand, captured with an accepted start
//   data_t     in   multiplier, captured with an accepted start
//   busy       out  high from the cycle after an accepted start until done drops
//   done       out  single-cycle pulse, product valid
//   result_hi  out  product bits [2*WIDTH-1:WIDTH]
//   result_lo  out  product bits [WIDTH-1:0]
//   prod_zero  out  held product equals zero
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] data_s,
  input  logic [WIDTH-1:0] data_t,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             prod_zero
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Magnitude of an operand; the most negative value maps onto itself,
  // which is still correct when read back as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic sgn, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    if (sgn && v[WIDTH-1]) begin
      m = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

  state_e           state_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_hi_q;
  logic [WIDTH-1:0] res_lo_q;
  logic             pzero_q;

  logic [WIDTH-1:0] mag_s_d;
  logic [WIDTH-1:0] mag_t_d;
  logic [PW-1:0]    sum_d;
  logic [PW-1:0]    neg_acc_d;

  // Operand conditioning and datapath next values.
  always_comb begin
    mag_s_d   = magnitude(sign, data_s);
    mag_t_d   = magnitude(sign, data_t);
    if (mplier_q[0]) begin
      sum_d = acc_q + mcand_q;
    end else begin
      sum_d = acc_q;
    end
    neg_acc_d = ~acc_q + {{(PW-1){1'b0}}, 1'b1};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q  <= ST_IDLE;
      acc_q    <= {PW{1'b0}};
      mcand_q  <= {PW{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_hi_q <= {WIDTH{1'b0}};
      res_lo_q <= {WIDTH{1'b0}};
      pzero_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // done from the previous operation drops here; busy follows start
          // so a held start restarts without a gap.
          done_q <= 1'b0;
          busy_q <= start;
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, mag_s_d};
            mplier_q <= mag_t_d;
            neg_q    <= sign & (data_s[WIDTH-1] ^ data_t[WIDTH-1]);
            acc_q    <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            state_q  <= ST_RUN;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_q    <= sum_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          // Fixed iteration count, no early exit on a zero multiplier.
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= ST_SIGN;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_SIGN: begin
          if (neg_q) begin
            acc_q <= neg_acc_d;
          end else begin
            acc_q <= acc_q;
          end
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          res_hi_q <= acc_q[PW-1:WIDTH];
          res_lo_q <= acc_q[WIDTH-1:0];
          pzero_q  <= (acc_q == {PW{1'b0}});
          done_q   <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;
  assign prod_zero = pzero_q;

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential 32x32 multiplier that provides the multiply path alongside the ALU's iterative division path. It takes two 32-bit operands and forms the full 64-bit product by radix-2 shift-add over a fixed number of cycles. Signed and unsigned modes are supported. A start/busy/done handshake lets the control unit stall while it runs, and the product is held until the next accepted start.

## Interface
Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH. Only 32 is verified.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  synchronous, active-high reset. Asserted = 1 despite the name.
- start  in  1  request; sampled only in IDLE.
- sign  in  1  1 = operands are two's-complement signed, 0 = unsigned; sampled with start.
- data_s  in  32  multiplicand; sampled with start.
- data_t  in  32  multiplier; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done drops.
- done  out  1  one-cycle pulse; result valid.
- result_hi  out  32  product bits [63:32].
- result_lo  out  32  product bits [31:0].
- prod_zero  out  1  1 when the held 64-bit product equals 0.

## Operation
- The FSM has four states: IDLE, RUN, SIGN and DONE.
- IDLE:
  - start=1 captures the operands and moves to RUN.
  - At capture, when sign=1, each operand is replaced by its magnitude: a negative value is negated. The magnitude of 0x80000000 is 0x80000000, read as unsigned.
  - neg_flag is captured as sign & (data_s[31] ^ data_t[31]).
  - The accumulator (64 bits) and the counter (6 bits) are cleared.
- RUN, one iteration per cycle:
  - If multiplier bit 0 = 1, the accumulator adds the multiplicand.
  - The multiplicand (64-bit register) shifts left 1.
  - The multiplier shifts right 1.
  - The counter increments.
  - After exactly 32 iterations the FSM moves to SIGN. There is no early termination.
- SIGN: if neg_flag=1, the accumulator is replaced by its 64-bit two's-complement negation, truncated to 64 bits. The FSM then moves to DONE.
- DONE:
  - Loads result_hi/result_lo from the accumulator.
  - done=1 for this one cycle; the FSM then returns to IDLE.
- Results and prod_zero hold their values until the next DONE or reset.
- Arithmetic is modulo 2^64. Unsigned 32x32 cannot overflow. In signed mode the product always fits in 64 bits.
- start outside IDLE (RUN, SIGN or DONE) is ignored. No queuing.
- Operand inputs are don't-care except in the cycle start is accepted.

## Timing
- Reset (rstn=1 at an edge): state goes to IDLE; busy=0, done=0, result_hi=0, result_lo=0, prod_zero=1. The internal accumulator, counter and neg_flag are cleared.
- Reset overrides everything, including start in the same cycle and an operation mid-RUN. A reset mid-run aborts with no done pulse, and the results are zeroed.
- Let edge E0 be the edge that samples start=1 in IDLE:
  - Edges E1..E32 are the RUN iterations.
  - E33 is SIGN.
  - At E34 the FSM enters DONE.
- Outputs relative to E0:
  - busy is high after E0 through the DONE cycle, and low after E35.
  - done is high for exactly the cycle between E34 and E35.
  - result_hi, result_lo and prod_zero update at E34.
- Latency is 34 cycles from start sample to done. Throughput is one operation per 35 cycles.
- Back-to-back: start held high is next accepted at E35 (IDLE). done and busy are never low for the same operation before results are valid.
- The result registers do not change during RUN or SIGN; the previous product stays visible.

## Test plan
- Unsigned basic: sign=0, data_s=3, data_t=5, start one cycle. Required: done pulses exactly 34 cycles after the start edge; result_hi=0x00000000, result_lo=0x0000000F, prod_zero=0; busy high for 35 cycles.
- Unsigned max: data_s=data_t=0xFFFFFFFF, sign=0. Required: result_hi=0xFFFFFFFE, result_lo=0x00000001.
- Signed cases:
  - -3 × 7 (0xFFFFFFFD, 0x00000007), sign=1. Required: result={0xFFFFFFFF, 0xFFFFFFEB}.
  - 0x80000000 × 0x80000000, sign=1. Required: {0x40000000, 0x00000000}.
  - -1 × 0, sign=1. Required: {0, 0} and prod_zero=1.
- Start while busy: start=1 with 3×5, then start=1 with 9×9 at E10. Required: result=15 at E34; the second start is ignored with no second done; start=1 at E35 with 9×9 yields 81 at E69.
- Reset mid-operation: start with 0x12345678 × 0x10, assert rstn at E20 for one cycle. Required: no done pulse; busy=0, results=0, prod_zero=1 after that edge. A new start afterwards gives the correct product with full 34-cycle latency.
- Result hold: after a completed 6×7=42, toggle data_s/data_t/sign for 50 cycles with start=0. Required: result_lo stays 0x0000002A, done stays 0.
